// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-style instruction decode stage with an ID/EX pipeline
// register, a small writeback-destination scoreboard for RAW hazard detection
// and a saturating hazard-stall counter.
// Optional feature macro: ID_FORWARD_EN. When it is defined, execute-stage
// forwarding is assumed and only load-use hazards against the ID/EX entry stall.

// control_unit: maps mode/opcode/S to execute command and pipeline enables.
module control_unit (
    input  logic [1:0] mode_i,
    input  logic [3:0] opcode_i,
    input  logic       s_i,
    output logic [3:0] exe_cmd_o,
    output logic       wb_en_o,
    output logic       mem_r_en_o,
    output logic       mem_w_en_o,
    output logic       b_o,
    output logic       s_o
);
    // Decode the instruction class into the control word
    always_comb begin
        exe_cmd_o  = '0;
        wb_en_o    = 1'b0;
        mem_r_en_o = 1'b0;
        mem_w_en_o = 1'b0;
        b_o        = 1'b0;
        s_o        = 1'b0;
        case (mode_i)
            2'b00: begin
                s_o = s_i;
                case (opcode_i)
                    4'b1101: begin exe_cmd_o = 4'b0001; wb_en_o = 1'b1; end // MOV
                    4'b1111: begin exe_cmd_o = 4'b1001; wb_en_o = 1'b1; end // MVN
                    4'b0100: begin exe_cmd_o = 4'b0010; wb_en_o = 1'b1; end // ADD
                    4'b0101: begin exe_cmd_o = 4'b0011; wb_en_o = 1'b1; end // ADC
                    4'b0010: begin exe_cmd_o = 4'b0100; wb_en_o = 1'b1; end // SUB
                    4'b0110: begin exe_cmd_o = 4'b0101; wb_en_o = 1'b1; end // SBC
                    4'b0000: begin exe_cmd_o = 4'b0110; wb_en_o = 1'b1; end // AND
                    4'b1100: begin exe_cmd_o = 4'b0111; wb_en_o = 1'b1; end // ORR
                    4'b0001: begin exe_cmd_o = 4'b1000; wb_en_o = 1'b1; end // EOR
                    4'b1010: exe_cmd_o = 4'b0100;                           // CMP
                    4'b1000: exe_cmd_o = 4'b0110;                           // TST
                    default: ;
                endcase
            end
            2'b01: begin
                // Memory: address = rn + offset; S selects load vs store
                exe_cmd_o = 4'b0010;
                if (s_i) begin
                    mem_r_en_o = 1'b1;
                    wb_en_o    = 1'b1;
                end else begin
                    mem_w_en_o = 1'b1;
                end
            end
            2'b10:   b_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// condition_check: evaluates the ARM condition field against {N,Z,C,V}.
module condition_check (
    input  logic [3:0] cond_i,
    input  logic [3:0] status_i,
    output logic       pass_o
);
    logic n, z, c, v;
    assign n = status_i[3];
    assign z = status_i[2];
    assign c = status_i[1];
    assign v = status_i[0];

    // Condition code evaluation
    always_comb begin
        pass_o = 1'b1;
        case (cond_i)
            4'h0:    pass_o = z;
            4'h1:    pass_o = ~z;
            4'h2:    pass_o = c;
            4'h3:    pass_o = ~c;
            4'h4:    pass_o = n;
            4'h5:    pass_o = ~n;
            4'h6:    pass_o = v;
            4'h7:    pass_o = ~v;
            4'h8:    pass_o = c & ~z;
            4'h9:    pass_o = ~c | z;
            4'hA:    pass_o = (n == v);
            4'hB:    pass_o = (n != v);
            4'hC:    pass_o = ~z & (n == v);
            4'hD:    pass_o = z | (n != v);
            default: pass_o = 1'b1;
        endcase
    end
endmodule

module id_stage_pipe #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned SB_DEPTH = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    input  logic [3:0]       status,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_ready,
    output logic             hazard,
    output logic [3:0]       r1,
    output logic [3:0]       r2,
    output logic             id_valid,
    output logic             wb_en,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic [3:0]       exe_cmd,
    output logic             b,
    output logic             s,
    output logic [PC_W-1:0]  pc,
    output logic [3:0]       src1,
    output logic [3:0]       src2,
    output logic             imm,
    output logic [11:0]      shift_op,
    output logic [23:0]      signed_imm,
    output logic [3:0]       dest,
    output logic             carry_in,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic            valid;
        logic            wb_en;
        logic            mem_r_en;
        logic            mem_w_en;
        logic [3:0]      exe_cmd;
        logic            b;
        logic            s;
        logic [PC_W-1:0] pc;
        logic [3:0]      src1;
        logic [3:0]      src2;
        logic            imm;
        logic [11:0]     shift_op;
        logic [23:0]     signed_imm;
        logic [3:0]      dest;
        logic            carry_in;
    } idex_t;

    idex_t            idex_q, idex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [3:0] cond_f, opcode_f, rn_f, rd_f, rm_f;
    logic [1:0] mode_f;
    logic       i_f, s_f;

    logic [3:0] cu_exe_cmd;
    logic       cu_wb_en, cu_mem_r_en, cu_mem_w_en, cu_b, cu_s;
    logic       cond_pass;
    logic       src2_used;
    logic [3:0] r2_sel;
    logic       raw_hit;
    logic       load;

    assign cond_f   = if_inst[31:28];
    assign mode_f   = if_inst[27:26];
    assign i_f      = if_inst[25];
    assign opcode_f = if_inst[24:21];
    assign s_f      = if_inst[20];
    assign rn_f     = if_inst[19:16];
    assign rd_f     = if_inst[15:12];
    assign rm_f     = if_inst[3:0];

    control_unit u_cu (
        .mode_i     (mode_f),
        .opcode_i   (opcode_f),
        .s_i        (s_f),
        .exe_cmd_o  (cu_exe_cmd),
        .wb_en_o    (cu_wb_en),
        .mem_r_en_o (cu_mem_r_en),
        .mem_w_en_o (cu_mem_w_en),
        .b_o        (cu_b),
        .s_o        (cu_s)
    );

    condition_check u_cc (
        .cond_i   (cond_f),
        .status_i (status),
        .pass_o   (cond_pass)
    );

    // Stores read rd as the second operand (data to be written to memory)
    assign r2_sel    = cu_mem_w_en ? rd_f : rm_f;
    assign src2_used = ~i_f | cu_mem_r_en | cu_mem_w_en;
    assign r1        = rn_f;
    assign r2        = r2_sel;

`ifdef ID_FORWARD_EN
    // Only a load still sitting in ID/EX cannot be forwarded in time
    assign raw_hit = idex_q.wb_en & idex_q.mem_r_en &
                     ((idex_q.dest == rn_f) | (src2_used & (idex_q.dest == r2_sel)));
`else
    logic       sb_v_q    [SB_DEPTH];
    logic [3:0] sb_dest_q [SB_DEPTH];

    // RAW check of both source operands against every in-flight destination
    always_comb begin
        raw_hit = 1'b0;
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            if (sb_v_q[k] && ((sb_dest_q[k] == rn_f) ||
                              (src2_used && (sb_dest_q[k] == r2_sel)))) begin
                raw_hit = 1'b1;
            end
        end
    end

    // Destination shift register; entry 0 tracks what enters ID/EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < SB_DEPTH; k++) begin
                sb_v_q[k]    <= 1'b0;
                sb_dest_q[k] <= '0;
            end
        end else if (ex_ready) begin
            sb_v_q[0]    <= idex_d.wb_en;
            sb_dest_q[0] <= idex_d.dest;
            for (int unsigned k = 1; k < SB_DEPTH; k++) begin
                sb_v_q[k]    <= sb_v_q[k-1];
                sb_dest_q[k] <= sb_dest_q[k-1];
            end
        end
    end
`endif

    assign hazard   = if_valid & raw_hit;
    assign id_ready = ex_ready & ~hazard;
    assign load     = if_valid & ~hazard & ~flush & cond_pass;

    // Next ID/EX contents: decoded instruction or an all-zero bubble
    always_comb begin
        idex_d = '0;
        if (load) begin
            idex_d.valid      = 1'b1;
            idex_d.wb_en      = cu_wb_en;
            idex_d.mem_r_en   = cu_mem_r_en;
            idex_d.mem_w_en   = cu_mem_w_en;
            idex_d.exe_cmd    = cu_exe_cmd;
            idex_d.b          = cu_b;
            idex_d.s          = cu_s;
            idex_d.pc         = if_pc;
            idex_d.src1       = rn_f;
            idex_d.src2       = r2_sel;
            idex_d.imm        = i_f;
            idex_d.shift_op   = if_inst[11:0];
            idex_d.signed_imm = if_inst[23:0];
            idex_d.dest       = rd_f;
            idex_d.carry_in   = status[1];
        end
    end

    // Saturating count of cycles lost to hazards (flushed cycles excluded)
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // ID/EX register and stall counter advance only when execute accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
        end else if (ex_ready) begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_valid   = idex_q.valid;
    assign wb_en      = idex_q.wb_en;
    assign mem_r_en   = idex_q.mem_r_en;
    assign mem_w_en   = idex_q.mem_w_en;
    assign exe_cmd    = idex_q.exe_cmd;
    assign b          = idex_q.b;
    assign s          = idex_q.s;
    assign pc         = idex_q.pc;
    assign src1       = idex_q.src1;
    assign src2       = idex_q.src2;
    assign imm        = idex_q.imm;
    assign shift_op   = idex_q.shift_op;
    assign signed_imm = idex_q.signed_imm;
    assign dest       = idex_q.dest;
    assign carry_in   = idex_q.carry_in;
    assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: issued instructions are queued as expected ID/EX
// packets and compared when the stage loads them; stall counts, hazard flags,
// hold, flush, condition-fail and reset behaviour are checked directly.
module tb_id_stage_pipe;
    localparam int unsigned PCW     = 32;
    localparam int unsigned CW      = 3;
    localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef ID_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] I_ADD_R1  = 32'hE0821003; // ADD r1,r2,r3
    localparam logic [31:0] I_SUB_R4  = 32'hE2414001; // SUB r4,r1,#1
    localparam logic [31:0] I_LDR_R1  = 32'hE4921000; // LDR r1,[r2]
    localparam logic [31:0] I_ADD_R5  = 32'hE0815001; // ADD r5,r1,r1
    localparam logic [31:0] I_MOV_R7  = 32'hE3A07005; // MOV r7,#5
    localparam logic [31:0] I_STR_R7  = 32'hE4827000; // STR r7,[r2]
    localparam logic [31:0] I_MOVEQ   = 32'h03A03001; // MOVEQ r3,#1

    logic            clk = 1'b0;
    logic            rst, if_valid, flush, ex_ready;
    logic [PCW-1:0]  if_pc;
    logic [31:0]     if_inst;
    logic [3:0]      status;
    logic            id_ready, hazard, id_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, carry_in;
    logic [3:0]      r1, r2, exe_cmd, src1, src2, dest;
    logic [PCW-1:0]  pc;
    logic [11:0]     shift_op;
    logic [23:0]     signed_imm;
    logic [CW-1:0]   stall_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        wb, mr, mw, br;
        logic [3:0]  dest, src1, src2;
        logic        imm, cin;
        logic [11:0] sh;
        logic [23:0] simm;
    } pkt_t;

    pkt_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_stall = 0;
    logic [31:0] pc_ctr = 32'h100;

    id_stage_pipe #(.PC_W(PCW), .SB_DEPTH(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .status(status), .flush(flush), .ex_ready(ex_ready), .id_ready(id_ready),
        .hazard(hazard), .r1(r1), .r2(r2), .id_valid(id_valid), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .exe_cmd(exe_cmd), .b(b), .s(s),
        .pc(pc), .src1(src1), .src2(src2), .imm(imm), .shift_op(shift_op),
        .signed_imm(signed_imm), .dest(dest), .carry_in(carry_in), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one instruction until accepted; called and returns at a negedge
    task automatic send(input logic [31:0] inst, input logic [3:0] st, input int exp_stalls,
                        input logic exp_issue, input logic [3:0] cmd, input logic wb,
                        input logic mr, input logic mw, input logic [3:0] s2);
        int   stalls;
        bit   acc;
        pkt_t p;
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc_ctr;
        status   = st;
        stalls   = 0;
        acc      = 1'b0;
        for (int c = 0; c < 16 && !acc; c++) begin
            #1;
            if (id_ready) begin
                acc = 1'b1;
                if (exp_issue) begin
                    p.pc = pc_ctr; p.cmd = cmd; p.wb = wb; p.mr = mr; p.mw = mw; p.br = 1'b0;
                    p.dest = inst[15:12]; p.src1 = inst[19:16]; p.src2 = s2;
                    p.imm = inst[25]; p.cin = st[1]; p.sh = inst[11:0]; p.simm = inst[23:0];
                    exp_q.push_back(p);
                end
            end else begin
                stalls++;
                check("hazard_on_stall", hazard, 1);
            end
            @(negedge clk);
        end
        if_valid  = 1'b0;
        exp_stall = (exp_stall + stalls > CNT_MAX) ? CNT_MAX : exp_stall + stalls;
        check("accepted", acc, 1);
        check("stall_cycles", stalls, exp_stalls);
        check("id_valid_after_accept", id_valid, exp_issue);
        check("stall_cnt", stall_cnt, exp_stall);
        pc_ctr += 4;
    endtask

    task automatic drain(input int n);
        if_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Compare each newly loaded valid ID/EX entry with the oldest expectation
    always @(posedge clk) begin : monitor
        logic adv;
        pkt_t got, e;
        adv = ex_ready & ~rst;
        #1;
        if (adv && !rst && id_valid) begin
            got.pc = pc; got.cmd = exe_cmd; got.wb = wb_en; got.mr = mem_r_en; got.mw = mem_w_en;
            got.br = b; got.dest = dest; got.src1 = src1; got.src2 = src2; got.imm = imm;
            got.cin = carry_in; got.sh = shift_op; got.simm = signed_imm;
            check("issue_was_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("idex_packet", got, e);
            end
        end
    end

    initial begin
        logic [31:0] hold_pc;
        int          hold_cnt;
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        if_pc = '0; if_inst = '0; status = 4'b0010;
        #1;
        check("reset_id_valid", id_valid, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_hazard", hazard, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back RAW on r1
        send(I_ADD_R1, 4'b0010, 0, 1, 4'b0010, 1, 0, 0, 4'd3);
        send(I_SUB_R4, 4'b0000, FWD ? 0 : 2, 1, 4'b0100, 1, 0, 0, 4'd1);

        // Execute back-pressure holds everything
        drain(2);
        send(I_ADD_R1, 4'b0010, 0, 1, 4'b0010, 1, 0, 0, 4'd3);
        ex_ready = 1'b0;
        if_valid = 1'b1; if_inst = I_SUB_R4; if_pc = pc_ctr;
        hold_pc  = pc_ctr - 4;
        hold_cnt = exp_stall;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_id_ready", id_ready, 0);
            @(negedge clk);
            check("hold_id_valid", id_valid, 1);
            check("hold_pc", pc, hold_pc);
            check("hold_stall_cnt", stall_cnt, hold_cnt);
        end
        ex_ready = 1'b1;
        send(I_SUB_R4, 4'b0000, FWD ? 0 : 2, 1, 4'b0100, 1, 0, 0, 4'd1);

        // Load-use
        drain(2);
        send(I_LDR_R1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 4'd0);
        send(I_ADD_R5, 4'b0000, FWD ? 1 : 2, 1, 4'b0010, 1, 0, 0, 4'd1);

        // Store data register read through r2 = rd
        drain(2);
        send(I_MOV_R7, 4'b0000, 0, 1, 4'b0001, 1, 0, 0, 4'd5);
        if_valid = 1'b1; if_inst = I_STR_R7; if_pc = pc_ctr;
        #1;
        check("str_r2", r2, 7);
        check("str_r1", r1, 2);
        check("str_hazard", hazard, !FWD);
        send(I_STR_R7, 4'b0000, FWD ? 0 : 2, 1, 4'b0010, 0, 0, 1, 4'd7);

        // Flush while the dependent instruction is in decode
        drain(2);
        send(I_ADD_R1, 4'b0010, 0, 1, 4'b0010, 1, 0, 0, 4'd3);
        if_valid = 1'b1; if_inst = I_SUB_R4; if_pc = pc_ctr; flush = 1'b1;
        #1;
        check("flush_hazard", hazard, !FWD);
        check("flush_id_ready", id_ready, FWD);
        @(negedge clk);
        check("flush_bubble", id_valid, 0);
        check("flush_stall_cnt", stall_cnt, exp_stall);
        flush = 1'b0; if_valid = 1'b0; pc_ctr += 4;

        // EQ condition: Z clear -> consumed as bubble, Z set -> issues
        send(I_MOVEQ, 4'b0000, 0, 0, 4'b0001, 1, 0, 0, 4'd1);
        send(I_MOVEQ, 4'b0110, 0, 1, 4'b0001, 1, 0, 0, 4'd1);

        // Asynchronous reset in the middle of a load-use stall
        drain(2);
        send(I_LDR_R1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 4'd0);
        if_valid = 1'b1; if_inst = I_ADD_R5; if_pc = pc_ctr;
        #1;
        check("pre_reset_hazard", hazard, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_id_valid", id_valid, 0);
        check("mid_reset_stall_cnt", stall_cnt, 0);
        check("mid_reset_hazard", hazard, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0;
        send(I_ADD_R5, 4'b0000, 0, 1, 4'b0010, 1, 0, 0, 4'd1);

        // Counter saturation
        for (int i = 0; i < 8; i++) begin
            send(I_LDR_R1, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 4'd0);
            send(I_ADD_R5, 4'b0000, FWD ? 1 : 2, 1, 4'b0010, 1, 0, 0, 4'd1);
        end
        check("saturated_stall_cnt", stall_cnt, CNT_MAX);

        drain(3);
        check("all_expected_issued", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
